lb2apb_bridge: RTL and testbench
================================

LB2APB_BRIDGE -- requirements
Module: lb2apb_bridge

Interface
REQ-001 Parameter ADDR_W, default 8, local bus and APB address width.
REQ-002 Parameter DATA_W, default 16, data width; SHALL be a multiple of 8.
REQ-003 Parameter STRB_W, default DATA_W/8, byte strobe width.
REQ-004 Parameter TIMEOUT, default 255, maximum ACCESS cycles without pready; 0 disables the timeout.
REQ-005 clk  in  1  system clock; all logic on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 lb_waddr  in  ADDR_W  write address.
REQ-008 lb_wdata  in  DATA_W  write data.
REQ-009 lb_wstrb  in  STRB_W  write byte strobes.
REQ-010 lb_wen  in  1  write request; held by the requester until lb_wready is seen.
REQ-011 lb_wready  out  1  one-cycle write-done pulse.
REQ-012 lb_raddr  in  ADDR_W  read address.
REQ-013 lb_ren  in  1  read request; held by the requester until lb_rvalid is seen.
REQ-014 lb_rdata  out  DATA_W  read data, valid with lb_rvalid.
REQ-015 lb_rvalid  out  1  one-cycle read-done pulse.
REQ-016 err  out  1  one-cycle pulse on pslverr or timeout completion.
REQ-017 psel, penable, pwrite  out  1 each  APB master control.
REQ-018 paddr  out  ADDR_W; pwdata  out  DATA_W; pstrb  out  STRB_W; pprot  out  3.
REQ-019 prdata  in  DATA_W; pready  in  1; pslverr  in  1.

Function
REQ-020 FSM states are IDLE, SETUP, ACCESS and DONE.
REQ-021 IDLE: lb_wen=1 -> capture waddr/wdata/wstrb, pwrite=1, go to SETUP; else lb_ren=1 -> capture raddr, pwrite=0, go to SETUP.
REQ-022 Simultaneous lb_wen and lb_ren in IDLE: the write wins; the read stays pending and is served after DONE.
REQ-023 SETUP: psel=1, penable=0 for exactly one cycle, then go to ACCESS.
REQ-024 ACCESS: psel=1, penable=1; paddr, pwrite, pwdata and pstrb stay stable until pready=1, then go to DONE.
REQ-025 Reads SHALL drive pstrb=0; pprot SHALL always be 3'b000.
REQ-026 On a read, prdata is registered into lb_rdata at the pready cycle; with pslverr=1, lb_rdata SHALL be 0.
REQ-027 Timeout counter clears on SETUP->ACCESS and increments each ACCESS cycle with pready=0.
REQ-028 Timeout: at count==TIMEOUT-1 with pready=0, go to DONE with error status, read data 0, APB signals dropped next cycle.
REQ-029 DONE lasts one cycle: psel=0, penable=0; lb_wready=1 (write) or lb_rvalid=1 (read); err=1 if pslverr or timeout; then go to IDLE.
REQ-030 DONE prevents re-acceptance of the still-asserted request; the requester drops it in the same cycle.
REQ-031 Minimum latency, request-in-IDLE to done pulse: 3 cycles with zero APB wait states (SETUP, ACCESS, DONE).
REQ-032 lb_rdata SHALL hold its value until the next read completes.
REQ-033 The timeout counter width SHALL be $clog2(TIMEOUT+1); there is no wrap in ACCESS.

Reset
REQ-034 Asynchronous rst=1 SHALL force state to IDLE and clear psel, penable, pwrite, paddr, pwdata, pstrb, lb_wready, lb_rvalid, lb_rdata, err and the counter to 0.
REQ-035 Reset mid-transfer SHALL abandon the transfer with no done pulse; after rst falls, a still-held request is re-issued from IDLE.

Structure
REQ-036 A shared package lb_apb_pkg SHALL hold the state encoding (2 bits) and the PPROT_DEFAULT constant.
REQ-037 Single module; no sub-module is required.

Verification
REQ-038 Write addr 0x12, data 0xBEEF, strb 2'b11, pready=1 at once -> SETUP then ACCESS, pwdata 0xBEEF, lb_wready pulse 3 cycles after wen.
REQ-039 Read addr 0x34, prdata 0x5A5A, pready after 4 wait cycles -> lb_rdata 0x5A5A, lb_rvalid pulse 7 cycles after ren, pstrb=0.
REQ-040 Write with pslverr=1 -> lb_wready pulse and err pulse in the same cycle; a read with pslverr -> lb_rdata 0.
REQ-041 TIMEOUT=4, pready held 0 -> after 4 ACCESS cycles: DONE, err=1, lb_rvalid=1, lb_rdata 0, psel low.
REQ-042 lb_wen and lb_ren asserted together -> APB write first, then read; exactly one wready pulse and one rvalid pulse.
REQ-043 rst asserted during ACCESS -> psel and penable low immediately, no done pulse; after release the held request restarts with SETUP.

Source files
------------

// File: rtl/lb_apb_pkg.sv
// Shared state encoding and constants for the local-bus to APB bridge.
package lb_apb_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2,
        StDone   = 2'd3
    } lb_apb_state_e;

    localparam logic [2:0] PPROT_DEFAULT = 3'b000;

endpackage

// File: rtl/lb2apb_bridge.sv
// Local-bus to APB master bridge: one transfer at a time, writes win over reads,
// optional ACCESS timeout that completes the transfer with an error.
module lb2apb_bridge
    import lb_apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned STRB_W  = DATA_W / 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lb_waddr,
    input  logic [DATA_W-1:0] lb_wdata,
    input  logic [STRB_W-1:0] lb_wstrb,
    input  logic              lb_wen,
    output logic              lb_wready,
    input  logic [ADDR_W-1:0] lb_raddr,
    input  logic              lb_ren,
    output logic [DATA_W-1:0] lb_rdata,
    output logic              lb_rvalid,
    output logic              err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic [STRB_W-1:0] pstrb,
    output logic [2:0]        pprot,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    lb_apb_state_e     r_state;
    lb_apb_state_e     w_state_next;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic [STRB_W-1:0] r_pstrb;
    logic              r_pwrite;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_timeout;

    assign w_timeout = (TIMEOUT != 0) && !pready && (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (lb_wen || lb_ren) w_state_next = StSetup;
            StSetup:  w_state_next = StAccess;
            StAccess: if (pready || w_timeout) w_state_next = StDone;
            StDone:   w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_comb begin
        psel      = (r_state == StSetup) || (r_state == StAccess);
        penable   = (r_state == StAccess);
        lb_wready = (r_state == StDone) && r_pwrite;
        lb_rvalid = (r_state == StDone) && !r_pwrite;
        err       = (r_state == StDone) && r_err;
    end

    // Request fields are captured only in IDLE so the APB side stays stable until DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pstrb  <= '0;
            r_pwrite <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (lb_wen) begin
                        r_paddr  <= lb_waddr;
                        r_pwdata <= lb_wdata;
                        r_pstrb  <= lb_wstrb;
                        r_pwrite <= 1'b1;
                    end else if (lb_ren) begin
                        r_paddr  <= lb_raddr;
                        r_pstrb  <= '0;
                        r_pwrite <= 1'b0;
                    end
                end
                StSetup: r_cnt <= '0;
                StAccess: begin
                    if (pready) begin
                        r_err <= pslverr;
                        if (!r_pwrite) r_rdata <= pslverr ? '0 : prdata;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                        if (!r_pwrite) r_rdata <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign paddr    = r_paddr;
    assign pwdata   = r_pwdata;
    assign pstrb    = r_pstrb;
    assign pwrite   = r_pwrite;
    assign pprot    = PPROT_DEFAULT;
    assign lb_rdata = r_rdata;

endmodule

// File: tb/tb_lb2apb_bridge.sv
// Self-checking bench for lb2apb_bridge: directed and random transfers against a
// cycle-schedule reference model, plus timeout and mid-transfer reset scenarios.
module tb_lb2apb_bridge;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 16;
    localparam int unsigned SW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] lb_waddr, lb_raddr, paddr, to_paddr;
    logic [DW-1:0] lb_wdata, lb_rdata, pwdata, prdata, to_rdata, to_pwdata;
    logic [SW-1:0] lb_wstrb, pstrb, to_pstrb;
    logic          lb_wen, lb_ren, lb_wready, lb_rvalid, err;
    logic          psel, penable, pwrite, pready, pslverr;
    logic [2:0]    pprot, to_pprot;
    logic          to_ren, to_pready, to_wready, to_rvalid, to_err;
    logic          to_psel, to_penable, to_pwrite;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] m_rdata;

    always #5 clk = ~clk;

    lb2apb_bridge #(.ADDR_W(AW), .DATA_W(DW), .STRB_W(SW)) u_dut (
        .clk(clk), .rst(rst),
        .lb_waddr(lb_waddr), .lb_wdata(lb_wdata), .lb_wstrb(lb_wstrb), .lb_wen(lb_wen),
        .lb_wready(lb_wready), .lb_raddr(lb_raddr), .lb_ren(lb_ren), .lb_rdata(lb_rdata),
        .lb_rvalid(lb_rvalid), .err(err), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    lb2apb_bridge #(.ADDR_W(AW), .DATA_W(DW), .STRB_W(SW), .TIMEOUT(4)) u_to (
        .clk(clk), .rst(rst),
        .lb_waddr(lb_waddr), .lb_wdata(lb_wdata), .lb_wstrb(lb_wstrb), .lb_wen(1'b0),
        .lb_wready(to_wready), .lb_raddr(lb_raddr), .lb_ren(to_ren), .lb_rdata(to_rdata),
        .lb_rvalid(to_rvalid), .err(to_err), .psel(to_psel), .penable(to_penable),
        .pwrite(to_pwrite), .paddr(to_paddr), .pwdata(to_pwdata), .pstrb(to_pstrb),
        .pprot(to_pprot), .prdata(prdata), .pready(to_pready), .pslverr(pslverr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Model: each transfer takes 3+waits cycles from request to done pulse; a read queued
    // behind a write starts one cycle after the write's done pulse.
    task automatic run(input bit dw, input bit dr, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic [SW-1:0] ws,
                       input logic [AW-1:0] ra, input int waits, input bit slv,
                       input logic [DW-1:0] prd);
        int            lat, exp_w, exp_r, last, s;
        bit            in_w;
        logic [DW-1:0] rd_new;
        lat    = 3 + waits;
        exp_w  = dw ? lat : -1;
        exp_r  = dr ? (dw ? 2 * lat + 1 : lat) : -1;
        last   = dr ? exp_r : exp_w;
        rd_new = slv ? '0 : prd;
        lb_waddr = wa; lb_wdata = wd; lb_wstrb = ws; lb_raddr = ra;
        lb_wen = dw; lb_ren = dr;
        prdata = prd; pslverr = slv; pready = 1'b0;
        for (int cyc = 1; cyc <= last + 1; cyc++) begin
            @(posedge clk); #1;
            in_w = dw && !(dr && cyc > lat);
            s    = (dw && dr && cyc > lat) ? lat + 1 : 0;
            chk("psel", psel, cyc >= s + 1 && cyc <= s + lat - 1);
            chk("penable", penable, cyc >= s + 2 && cyc <= s + lat - 1);
            if (cyc >= s + 1 && cyc <= s + lat - 1) begin
                chk("paddr", paddr, in_w ? wa : ra);
                chk("pwrite", pwrite, in_w);
                chk("pstrb", pstrb, in_w ? ws : '0);
                if (in_w) chk("pwdata", pwdata, wd);
            end
            chk("pprot", pprot, 3'b000);
            chk("wready", lb_wready, cyc == exp_w);
            chk("rvalid", lb_rvalid, cyc == exp_r);
            chk("err", err, slv && (cyc == exp_w || cyc == exp_r));
            if (cyc == exp_w) begin
                chk("rdata_hold", lb_rdata, m_rdata);
                lb_wen = 1'b0;
            end
            if (cyc == exp_r) begin
                chk("rdata", lb_rdata, rd_new);
                m_rdata = rd_new;
                lb_ren  = 1'b0;
            end
            pready = (cyc == s + lat - 1);
        end
        pready = 1'b0;
    endtask

    initial begin
        int last;
        int k;
        bit dw, dr;
        rst = 1'b1;
        lb_waddr = '0; lb_wdata = '0; lb_wstrb = '0; lb_wen = 1'b0;
        lb_raddr = '0; lb_ren = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
        to_ren = 1'b0; to_pready = 1'b0;
        m_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_pstrb", pstrb, 0);
        chk("rst_wready", lb_wready, 0);
        chk("rst_rvalid", lb_rvalid, 0);
        chk("rst_rdata", lb_rdata, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run(1, 0, 8'h12, 16'hBEEF, 2'b11, 8'h00, 0, 0, 16'h0000);
        run(0, 1, 8'h00, 16'h0000, 2'b00, 8'h34, 4, 0, 16'h5A5A);
        run(1, 0, 8'h21, 16'hCAFE, 2'b01, 8'h00, 1, 1, 16'h0000);
        run(0, 1, 8'h00, 16'h0000, 2'b00, 8'h43, 0, 1, 16'hFFFF);
        run(1, 1, 8'h60, 16'h1357, 2'b10, 8'h61, 1, 0, 16'h2468);

        for (int i = 0; i < 24; i++) begin
            k  = $urandom_range(0, 2);
            dw = (k != 1);
            dr = (k != 0);
            run(dw, dr, AW'($urandom), DW'($urandom), SW'($urandom), AW'($urandom),
                $urandom_range(0, 5), ($urandom_range(0, 3) == 0), DW'($urandom));
        end

        // TIMEOUT=4 instance: one normal read, then a read that never sees pready.
        for (int t = 0; t < 2; t++) begin
            last = (t == 0) ? 3 : 6;
            lb_raddr = 8'h77; prdata = 16'hA5C3; pslverr = 1'b0;
            to_ren = 1'b1; to_pready = 1'b0;
            for (int cyc = 1; cyc <= last + 1; cyc++) begin
                @(posedge clk); #1;
                chk("to_psel", to_psel, cyc >= 1 && cyc <= last - 1);
                chk("to_penable", to_penable, cyc >= 2 && cyc <= last - 1);
                chk("to_rvalid", to_rvalid, cyc == last);
                chk("to_err", to_err, (t == 1) && cyc == last);
                if (cyc == last) begin
                    chk("to_rdata", to_rdata, (t == 0) ? 16'hA5C3 : 16'h0000);
                    to_ren = 1'b0;
                end
                to_pready = (t == 0) && (cyc == 2);
            end
        end

        // Reset during ACCESS with the read request still held.
        lb_raddr = 8'h56; prdata = 16'h1234; pslverr = 1'b0; pready = 1'b0; lb_ren = 1'b1;
        @(posedge clk); #1;
        chk("mr_setup_psel", psel, 1);
        chk("mr_setup_pen", penable, 0);
        @(posedge clk); #1;
        chk("mr_access_pen", penable, 1);
        #2 rst = 1'b1;
        #1;
        chk("mr_psel", psel, 0);
        chk("mr_penable", penable, 0);
        chk("mr_rdata", lb_rdata, 0);
        chk("mr_paddr", paddr, 0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("mr_rvalid", lb_rvalid, 0);
            chk("mr_err", err, 0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mr_re_psel", psel, 1);
        chk("mr_re_pen", penable, 0);
        chk("mr_re_paddr", paddr, 8'h56);
        @(posedge clk); #1;
        chk("mr_re_access", penable, 1);
        pready = 1'b1;
        @(posedge clk); #1;
        pready = 1'b0;
        chk("mr_re_rvalid", lb_rvalid, 1);
        chk("mr_re_rdata", lb_rdata, 16'h1234);
        lb_ren = 1'b0;
        @(posedge clk); #1;
        chk("mr_re_rvalid_end", lb_rvalid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
